// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the decode/execute hazard controller.
package pipeline_hazard_ctrl_pkg;

    // Sequencing FSM states (value is what state_o shows)
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // Operand forwarding selects; code 2 is reserved and never driven
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_WB = 2'd1;

    // mem_op encodings carried in the EX state register
    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// hazard_fwd_unit: pure combinational WB->EX operand forwarding compare.
// One compare per EX source operand; x0 is never forwarded.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic                 wb_valid,
    input  logic                 wb_wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [REG_IDX_W-1:0] ex_rs1,
    input  logic [REG_IDX_W-1:0] ex_rs2,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel
);

    // A pending WB write to a non-zero register that matches the source wins over the regfile
    function automatic logic [1:0] fwd_compare(input logic [REG_IDX_W-1:0] src);
        if (wb_valid && wb_wb_en && (wb_rd != '0) && (wb_rd == src))
            return FWD_WB;
        return FWD_RF;
    endfunction

    // Both operands use the same compare rule
    always_comb begin
        fwd_a_sel = fwd_compare(ex_rs1);
        fwd_b_sel = fwd_compare(ex_rs2);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall / bubble / freeze / flush / redirect sequencing
// for the decode-to-execute state register, plus EX operand forwarding selects.
// Optional build macro: PIPELINE_HAZARD_PERF_EN adds three 32-bit perf counters.
//
// Handshake: the controller has no valid/ready pair of its own; every control
// output is a same-cycle enable for the pipeline registers (zero latency).
// mem_req/mem_ack: a request seen with ex_valid and no ack in the same cycle
// freezes fetch, decode and EX until the cycle in which mem_ack is high.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_IDX_W      = 5,
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_OP_LOAD    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [1:0]           ex_mem_op,
    input  logic                 ex_wb_en,
    input  logic [REG_IDX_W-1:0] ex_rs1,
    input  logic [REG_IDX_W-1:0] ex_rs2,
    input  logic                 ex_br_taken,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_wb_en,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic                 hold_ex,
    output logic                 flush_id,
    output logic                 pc_redirect,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
`ifdef PIPELINE_HAZARD_PERF_EN
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_bubbles,
    output logic [31:0]          perf_flushes,
`endif
    output logic [1:0]           state_o
);

    localparam bit         MULTI_FLUSH = (BRANCH_PENALTY > 1);
    localparam logic [1:0] FLUSH_INIT  = 2'(BRANCH_PENALTY - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       mem_stall, br_taken, load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // ex_wb_en is carried for completeness; a load always writes, so the hazard keys on mem_op
    logic unused_ex_wb_en;
    assign unused_ex_wb_en = ex_wb_en;

    // Event decode shared by next-state and output logic
    always_comb begin
        mem_stall = ex_valid && mem_req && !mem_ack;
        br_taken  = ex_valid && ex_br_taken;
        load_use  = ex_valid && (ex_mem_op == 2'(MEM_OP_LOAD)) && (ex_rd != '0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // State and flush counter register; reset aborts any wait or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: memory wait dominates, a taken branch may open a multi-cycle flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (br_taken && MULTI_FLUSH) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_INIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    if (br_taken && MULTI_FLUSH) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Outputs: per-state control enables; reset forces all low except bubble_ex
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        hold_ex     = 1'b0;
        flush_id    = 1'b0;
        pc_redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    hold_ex  = 1'b1;
                end else if (br_taken) begin
                    pc_redirect = 1'b1;
                    flush_id    = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // No load-use check here; EX advances on the ack cycle and is checked next cycle
                if (!mem_ack) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    hold_ex  = 1'b1;
                end else if (br_taken) begin
                    pc_redirect = 1'b1;
                    flush_id    = 1'b1;
                    bubble_ex   = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            stall_if    = 1'b0;
            stall_id    = 1'b0;
            bubble_ex   = 1'b1;
            hold_ex     = 1'b0;
            flush_id    = 1'b0;
            pc_redirect = 1'b0;
        end
    end

    hazard_fwd_unit #(.REG_IDX_W(REG_IDX_W)) u_fwd (
        .wb_valid  (wb_valid),
        .wb_wb_en  (wb_wb_en),
        .wb_rd     (wb_rd),
        .ex_rs1    (ex_rs1),
        .ex_rs2    (ex_rs2),
        .fwd_a_sel (fwd_a_raw),
        .fwd_b_sel (fwd_b_raw)
    );

    // Forwarding selects read 0 while in reset
    always_comb begin
        fwd_a_sel = rst_n ? fwd_a_raw : FWD_RF;
        fwd_b_sel = rst_n ? fwd_b_raw : FWD_RF;
        state_o   = state_q;
    end

`ifdef PIPELINE_HAZARD_PERF_EN
    // Event counters; held at 0 in reset so reset-time bubbles are never counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= 32'd0;
            perf_bubbles      <= 32'd0;
            perf_flushes      <= 32'd0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + {31'd0, stall_id};
            perf_bubbles      <= perf_bubbles + {31'd0, bubble_ex};
            perf_flushes      <= perf_flushes + {31'd0, pc_redirect};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BRANCH_PENALTY = 2).
// Optional build macro: PIPELINE_HAZARD_PERF_EN also checks the perf counters.
module tb_pipeline_hazard_ctrl;

    localparam int W = 5;

    // Control bit order: {stall_if, stall_id, bubble_ex, hold_ex, flush_id, pc_redirect}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b111000;
    localparam logic [5:0] C_MEM  = 6'b110100;
    localparam logic [5:0] C_BR   = 6'b001011;
    localparam logic [5:0] C_FL   = 6'b001010;
    localparam logic [5:0] C_RST  = 6'b001000;

    typedef struct {
        logic         id_valid;
        logic [W-1:0] id_rs1;
        logic [W-1:0] id_rs2;
        logic         use1;
        logic         use2;
        logic         ex_valid;
        logic [W-1:0] ex_rd;
        logic [1:0]   ex_mem_op;
        logic [W-1:0] ex_rs1;
        logic [W-1:0] ex_rs2;
        logic         br;
        logic         wb_valid;
        logic [W-1:0] wb_rd;
        logic         wb_en;
        logic         mem_req;
        logic         mem_ack;
        logic [5:0]   exp_ctrl;
        logic [1:0]   exp_fa;
        logic [1:0]   exp_fb;
    } vec_t;

    logic         clk, rst_n;
    logic         id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_wb_en, ex_br_taken;
    logic [W-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, wb_rd;
    logic [1:0]   ex_mem_op;
    logic         wb_valid, wb_wb_en, mem_req, mem_ack;
    logic         stall_if, stall_id, bubble_ex, hold_ex, flush_id, pc_redirect;
    logic [1:0]   fwd_a_sel, fwd_b_sel, state_o;
`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0]  perf_stall_cycles, perf_bubbles, perf_flushes;
`endif

    int checks = 0;
    int failures = 0;
    int exp_stall = 0, exp_bub = 0, exp_flush = 0;
    vec_t vecs[16];
    vec_t v;

    logic [5:0] ctrl_now;
    assign ctrl_now = {stall_if, stall_id, bubble_ex, hold_ex, flush_id, pc_redirect};

    pipeline_hazard_ctrl #(.REG_IDX_W(W), .BRANCH_PENALTY(2), .MEM_OP_LOAD(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_mem_op   (ex_mem_op),
        .ex_wb_en    (ex_wb_en),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_br_taken (ex_br_taken),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_wb_en    (wb_wb_en),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .hold_ex     (hold_ex),
        .flush_id    (flush_id),
        .pc_redirect (pc_redirect),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
`ifdef PIPELINE_HAZARD_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubbles      (perf_bubbles),
        .perf_flushes      (perf_flushes),
`endif
        .state_o     (state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        id_valid    = x.id_valid;
        id_rs1      = x.id_rs1;
        id_rs2      = x.id_rs2;
        id_use_rs1  = x.use1;
        id_use_rs2  = x.use2;
        ex_valid    = x.ex_valid;
        ex_rd       = x.ex_rd;
        ex_mem_op   = x.ex_mem_op;
        ex_wb_en    = x.ex_valid;
        ex_rs1      = x.ex_rs1;
        ex_rs2      = x.ex_rs2;
        ex_br_taken = x.br;
        wb_valid    = x.wb_valid;
        wb_rd       = x.wb_rd;
        wb_wb_en    = x.wb_en;
        mem_req     = x.mem_req;
        mem_ack     = x.mem_ack;
    endtask

    function automatic vec_t idle();
        vec_t z;
        z = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0,
              1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 2'd0};
        return z;
    endfunction

    // Check the current cycle's outputs, account expected perf events, then clock once
    task automatic cycle(input string nm, input logic [5:0] ec, input logic [1:0] efa,
                         input logic [1:0] efb, input logic [1:0] est);
        #1;
        chk({nm, ".ctrl"},  {26'd0, ctrl_now},  {26'd0, ec});
        chk({nm, ".fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, efa});
        chk({nm, ".fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, efb});
        chk({nm, ".state"}, {30'd0, state_o},   {30'd0, est});
        exp_stall += int'(ec[4]);
        exp_bub   += int'(ec[3]);
        exp_flush += int'(ec[0]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Vector table: single cycles in RUN that never leave RUN
        //           idv rs1 rs2 u1 u2 exv rd op exr1 exr2 br wbv wbrd wben req ack ctrl fa fb
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0};
        vecs[1]  = '{1, 5, 2, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_LU,   0, 0};
        vecs[2]  = '{1, 3, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_LU,   0, 0};
        vecs[3]  = '{1, 5, 2, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0};
        vecs[4]  = '{1, 5, 2, 1, 0, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0};
        vecs[5]  = '{1, 5, 2, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0};
        vecs[6]  = '{0, 5, 2, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0};
        vecs[7]  = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 4, 0, 1, 9, 1, 0, 0, C_NONE, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 4, 0, 1, 4, 1, 0, 0, C_NONE, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0,12,12, 0, 1,12, 1, 0, 0, C_NONE, 1, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0,12,12, 0, 1,12, 0, 0, 0, C_NONE, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0,12,12, 0, 0,12, 1, 0, 0, C_NONE, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, C_NONE, 0, 0};
        vecs[14] = '{1, 5, 2, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, C_LU,   0, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0};

        // Reset: bubble_ex only, FSM in RUN
        rst_n = 1'b0;
        apply(idle());
        #12;
        chk("rst.ctrl",  {26'd0, ctrl_now}, {26'd0, C_RST});
        chk("rst.state", {30'd0, state_o},  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel.ctrl", {26'd0, ctrl_now}, {26'd0, C_NONE});
`ifdef PIPELINE_HAZARD_PERF_EN
        chk("perf.rst_stall", perf_stall_cycles, 32'd0);
        chk("perf.rst_bub",   perf_bubbles,      32'd0);
        chk("perf.rst_flush", perf_flushes,      32'd0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            cycle($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_fa, vecs[i].exp_fb, 2'd0);
        end

        // Load-use: exactly one stall cycle, then the load forwards from WB
        v = idle(); v.id_valid = 1; v.id_rs1 = 5; v.use1 = 1;
        v.ex_valid = 1; v.ex_rd = 5; v.ex_mem_op = 2'd1;
        apply(v); cycle("lu.c0", C_LU, 2'd0, 2'd0, 2'd0);
        v = idle(); v.id_valid = 1; v.id_rs1 = 8; v.use1 = 1;
        v.ex_rs1 = 5; v.wb_valid = 1; v.wb_rd = 5; v.wb_en = 1;
        apply(v); cycle("lu.c1", C_NONE, 2'd1, 2'd0, 2'd0);

        // Memory wait: ack three cycles after request, hazard in ID ignored during the wait
        v = idle(); v.ex_valid = 1; v.ex_rd = 5; v.ex_mem_op = 2'd1; v.mem_req = 1;
        v.id_valid = 1; v.id_rs1 = 6; v.use1 = 1;
        apply(v); cycle("mw.c0", C_MEM, 2'd0, 2'd0, 2'd0);
        v.id_rs1 = 5;
        apply(v); cycle("mw.c1", C_MEM, 2'd0, 2'd0, 2'd1);
        apply(v); cycle("mw.c2", C_MEM, 2'd0, 2'd0, 2'd1);
        v.mem_ack = 1;
        apply(v); cycle("mw.ack", C_NONE, 2'd0, 2'd0, 2'd1);
        v.mem_req = 0; v.mem_ack = 0;
        apply(v); cycle("mw.post", C_LU, 2'd0, 2'd0, 2'd0);
        apply(idle()); cycle("mw.idle", C_NONE, 2'd0, 2'd0, 2'd0);

        // Taken branch with a load-use pattern present: branch wins, two flush cycles
        v = idle(); v.id_valid = 1; v.id_rs1 = 5; v.use1 = 1;
        v.ex_valid = 1; v.ex_rd = 5; v.ex_mem_op = 2'd1; v.br = 1;
        apply(v); cycle("br.c0", C_BR, 2'd0, 2'd0, 2'd0);
        v.br = 0;
        apply(v); cycle("br.c1", C_FL, 2'd0, 2'd0, 2'd2);
        apply(idle()); cycle("br.c2", C_NONE, 2'd0, 2'd0, 2'd0);

        // Branch and memory op together: wait first, branch taken on the ack cycle
        v = idle(); v.ex_valid = 1; v.br = 1; v.mem_req = 1; v.ex_mem_op = 2'd2;
        apply(v); cycle("bm.c0", C_MEM, 2'd0, 2'd0, 2'd0);
        v.mem_ack = 1;
        apply(v); cycle("bm.ack", C_BR, 2'd0, 2'd0, 2'd1);
        apply(idle()); cycle("bm.c2", C_FL, 2'd0, 2'd0, 2'd2);
        apply(idle()); cycle("bm.c3", C_NONE, 2'd0, 2'd0, 2'd0);

`ifdef PIPELINE_HAZARD_PERF_EN
        chk("perf.stall", perf_stall_cycles, 32'(exp_stall));
        chk("perf.bub",   perf_bubbles,      32'(exp_bub));
        chk("perf.flush", perf_flushes,      32'(exp_flush));
`endif

        // Reset in the middle of a memory wait aborts it at once
        v = idle(); v.ex_valid = 1; v.ex_rd = 3; v.ex_mem_op = 2'd1; v.mem_req = 1;
        v.wb_valid = 1; v.wb_en = 1; v.wb_rd = 4; v.ex_rs2 = 4;
        apply(v); cycle("rmw.c0", C_MEM, 2'd0, 2'd1, 2'd0);
        chk("rmw.in_wait", {30'd0, state_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmw.ctrl",  {26'd0, ctrl_now},  {26'd0, C_RST});
        chk("rmw.state", {30'd0, state_o},   32'd0);
        chk("rmw.fwd_b", {30'd0, fwd_b_sel}, 32'd0);
        apply(idle());
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0; exp_bub = 0; exp_flush = 0;
        #1;
        chk("rmw.rel_ctrl",  {26'd0, ctrl_now}, {26'd0, C_NONE});
        chk("rmw.rel_state", {30'd0, state_o},  32'd0);
`ifdef PIPELINE_HAZARD_PERF_EN
        chk("perf.rst2_stall", perf_stall_cycles, 32'd0);
        chk("perf.rst2_bub",   perf_bubbles,      32'd0);
        chk("perf.rst2_flush", perf_flushes,      32'd0);
`endif
        @(posedge clk);
        #1;

        // x0 guard after reset: no stall on rd=0 load, no forwarding of x0
        v = idle(); v.id_valid = 1; v.id_rs1 = 0; v.use1 = 1;
        v.ex_valid = 1; v.ex_rd = 0; v.ex_mem_op = 2'd1;
        v.wb_valid = 1; v.wb_en = 1; v.wb_rd = 0; v.ex_rs2 = 0;
        apply(v); cycle("x0.c0", C_NONE, 2'd0, 2'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the decode-to-execute state register that carries pc, rs1_val, rs2_val, imm, valid, alu_op, mem_op, wb_op, br_op, funct3, rd, rs1, rs2 and alu_result.
- Per cycle it decides one of: hold fetch/decode, insert a bubble (valid=0) into the EX state register, freeze EX, flush decode, or redirect fetch.
- It also drives operand-forwarding selects for EX.
- It sits beside the decode/execute register, between fetch/decode and the data-memory port.

Parameters:
- REG_IDX_W, 5, register index width (matches rd/rs1/rs2).
- BRANCH_PENALTY, 1, bubble cycles inserted after a taken branch (1..3).
- MEM_OP_LOAD, 1, mem_op encoding for a load (mem_op is 2 bits; 0 = none, 2 = store).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  REG_IDX_W  decode source register 1
- id_rs2  in  REG_IDX_W  decode source register 2
- id_use_rs1  in  1  decode instruction reads rs1
- id_use_rs2  in  1  decode instruction reads rs2
- ex_valid  in  1  EX state valid bit
- ex_rd  in  REG_IDX_W  EX destination
- ex_mem_op  in  2  EX mem_op
- ex_wb_en  in  1  EX writes a register
- ex_rs1  in  REG_IDX_W  EX source register 1 (forwarding)
- ex_rs2  in  REG_IDX_W  EX source register 2 (forwarding)
- ex_br_taken  in  1  EX branch resolved taken
- wb_valid  in  1  WB stage valid
- wb_rd  in  REG_IDX_W  WB destination
- wb_wb_en  in  1  WB writes a register
- mem_req  in  1  data-memory request issued by EX
- mem_ack  in  1  data-memory response
- stall_if  out  1  hold PC
- stall_id  out  1  hold decode register
- bubble_ex  out  1  load valid=0 into EX state
- hold_ex  out  1  freeze EX state register
- flush_id  out  1  invalidate decode register
- pc_redirect  out  1  fetch takes branch target this cycle
- fwd_a_sel  out  2  0 = regfile, 1 = WB result, 2 = reserved
- fwd_b_sel  out  2  same encoding for rs2
- state_o  out  2  FSM state (debug)

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to RUN and the flush counter goes to 0.
  - All outputs read 0, with one exception: bubble_ex = 1 while rst_n is low, so EX comes out of reset invalid.
  - Reset mid-MEM_WAIT or mid-FLUSH aborts immediately.
- FSM states: RUN (0), MEM_WAIT (1), FLUSH (2).
- RUN, evaluated in priority order:
  1. ex_valid & mem_req & !mem_ack -> next MEM_WAIT. In the same cycle assert stall_if, stall_id and hold_ex.
  2. ex_valid & ex_br_taken -> assert pc_redirect, flush_id and bubble_ex. If BRANCH_PENALTY > 1, next FLUSH with counter = BRANCH_PENALTY-1.
  3. Load-use hazard -> assert stall_if, stall_id and bubble_ex for exactly 1 cycle; stay in RUN. The hazard condition is all of:
     - ex_valid and ex_mem_op == MEM_OP_LOAD and ex_rd != 0;
     - id_valid;
     - (id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd).
  4. Otherwise all control outputs are 0.
- MEM_WAIT:
  - stall_if, stall_id and hold_ex stay high.
  - On mem_ack -> RUN. The EX register advances that same cycle (hold_ex low).
  - A load-use check against the new EX content runs in the next RUN cycle, never during the wait.
- FLUSH:
  - flush_id and bubble_ex stay high and the counter decrements.
  - When the counter reaches 0 -> RUN.
  - pc_redirect does not repeat.
- Simultaneous events:
  - A taken branch overrides load-use, because the decode instruction is wrong-path.
  - Memory wait overrides everything.
  - A branch and a memory op in EX are mutually exclusive by decode; if both appear, memory wait wins and the branch is taken when the wait exits.
- Forwarding (combinational):
  - fwd_a_sel = 1 when wb_valid & wb_wb_en & wb_rd != 0 & wb_rd == ex_rs1, else 0.
  - fwd_b_sel is the same rule against ex_rs2.
  - x0 is never forwarded.
  - Code 2 is never driven.
- All control outputs are registered-state driven or combinational from inputs, with zero-cycle latency to the pipeline enables.

Optional Feature:
- Macro: PIPELINE_HAZARD_PERF_EN.
- When defined, add three 32-bit outputs: perf_stall_cycles, perf_bubbles and perf_flushes.
  - perf_stall_cycles counts cycles with stall_id high.
  - perf_bubbles counts cycles with bubble_ex high, excluding reset.
  - perf_flushes counts pc_redirect pulses.
- All three reset to 0 and wrap modulo 2^32.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pipeline_hazard_ctrl_pkg holds:
  - the FSM state enum (RUN/MEM_WAIT/FLUSH);
  - fwd select constants (FWD_RF = 0, FWD_WB = 1);
  - mem_op encodings (MEM_NONE = 0, MEM_LOAD = 1, MEM_STORE = 2).
- One sub-module, hazard_fwd_unit, holds the pure combinational forwarding compare, instantiated once and shared by both operands via two compare instances.

Test Plan:
- Reset: assert rst_n=0 mid-MEM_WAIT -> state_o=0 and bubble_ex=1 immediately. After release, all outputs are 0 with no inputs active.
- Load-use: EX holds a load with rd=5, ID has rs1=5 used -> exactly one cycle of stall_if=stall_id=bubble_ex=1. Next cycle the load is in WB with wb_rd=5 -> fwd_a_sel=1.
- Memory wait: EX load with mem_req=1, mem_ack delayed 3 cycles -> hold_ex high for 3 cycles, state_o=1. On the ack cycle hold_ex=0 and the state returns to 0.
- Branch: BRANCH_PENALTY=2, ex_br_taken=1 -> pc_redirect for 1 cycle, flush_id/bubble_ex for 2 cycles. A load-use hazard present at the same time produces no extra stall.
- x0 guard: load with rd=0 and ID rs1=0 -> no stall. wb_rd=0 matching ex_rs2=0 -> fwd_b_sel=0.
- Perf (macro on): run the above sequence -> counters equal the exact stall, bubble and flush counts, and read 0 after reset.
